imem_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read instruction memory between two requesters: port 0 (core fetch, read-only) and port 1 (program loader/debug, read/write).
- Sits between the fetch stage and loader on one side and the instruction RAM on the other.
- Arbitrates one access per cycle, tracks the single outstanding read, routes the response back one cycle later, and filters out-of-range addresses.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 57 +++++
 rtl/imem_arbiter.sv | 104 ++++++++++
 tb/tb_imem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory arbiter
package imem_pkg;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LOAD  = 1'b1;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef struct packed {
      logic valid;
      logic owner;
      logic we;
      logic oob;
   } pend_t;

   // Unsigned compare on the full byte address; low bits count too.
   function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] limit);
      return addr >= limit;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input arbiter with round-robin pointer, fixed mode and loader lock
module rr_arbiter2
   import imem_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       fixed_i,
   input  logic       lock_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic rr_ptr;
   logic lock_owner;
   logic lock_active;

   // A held lock only counts while the loader keeps lock_i high, so port 0
   // regains eligibility in the very cycle the lock drops.
   assign lock_active = lock_owner & lock_i;

   always_comb begin
      gnt_o = 2'b00;
      if (rst_ni) begin
         if (lock_active) begin
            gnt_o[PORT_LOAD] = req_i[PORT_LOAD];
         end else if (req_i[PORT_FETCH] && req_i[PORT_LOAD]) begin
            if (fixed_i || (rr_ptr == PORT_FETCH)) begin
               gnt_o[PORT_FETCH] = 1'b1;
            end else begin
               gnt_o[PORT_LOAD] = 1'b1;
            end
         end else begin
            gnt_o = req_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr     <= PORT_FETCH;
         lock_owner <= 1'b0;
      end else begin
         if (gnt_o[PORT_FETCH]) begin
            rr_ptr <= PORT_LOAD;
         end else if (gnt_o[PORT_LOAD]) begin
            rr_ptr <= PORT_FETCH;
         end

         if (!lock_i) begin
            lock_owner <= 1'b0;
         end else if (gnt_o[PORT_LOAD]) begin
            lock_owner <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - shares one synchronous-read instruction RAM between fetch and loader
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int MEM_SIZE_BYTES = 4096,
   parameter int ARB_MODE       = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        req0_i,
   input  logic [31:0] addr0_i,
   output logic        gnt0_o,
   output logic        rvalid0_o,
   output logic [31:0] rdata0_o,
   output logic        err0_o,

   input  logic        req1_i,
   input  logic        we1_i,
   input  logic [31:0] addr1_i,
   input  logic [31:0] wdata1_i,
   input  logic        lock1_i,
   output logic        gnt1_o,
   output logic        rvalid1_o,
   output logic [31:0] rdata1_o,
   output logic        err1_o,

   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [29:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [31:0] MEM_LIMIT   = 32'(MEM_SIZE_BYTES);
   localparam logic        FIXED_PRIO  = (ARB_MODE == ARB_FIXED);

   logic [1:0]  gnt;
   logic        gnt_any;
   logic        sel;
   logic [31:0] addr_sel;
   logic        oob;
   pend_t       pend_d;
   pend_t       pend_q;

   rr_arbiter2 u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .fixed_i (FIXED_PRIO),
      .lock_i  (lock1_i),
      .req_i   ({req1_i, req0_i}),
      .gnt_o   (gnt)
   );

   assign gnt0_o = gnt[PORT_FETCH];
   assign gnt1_o = gnt[PORT_LOAD];

   always_comb begin
      gnt_any  = |gnt;
      sel      = gnt[PORT_LOAD] ? PORT_LOAD : PORT_FETCH;
      addr_sel = (sel == PORT_LOAD) ? addr1_i : addr0_i;
      oob      = addr_oob(addr_sel, MEM_LIMIT);

      // Out-of-range grants still produce a response, just without touching RAM.
      mem_req_o   = gnt_any & ~oob;
      mem_we_o    = mem_req_o & (sel == PORT_LOAD) & we1_i;
      mem_addr_o  = addr_sel[31:2];
      mem_wdata_o = wdata1_i;

      pend_d.valid = gnt_any;
      pend_d.owner = sel;
      pend_d.we    = (sel == PORT_LOAD) & we1_i;
      pend_d.oob   = oob;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   always_comb begin
      rvalid0_o = 1'b0;
      rdata0_o  = '0;
      err0_o    = 1'b0;
      rvalid1_o = 1'b0;
      rdata1_o  = '0;
      err1_o    = 1'b0;
      if (rst_ni && pend_q.valid) begin
         if (pend_q.owner == PORT_LOAD) begin
            rvalid1_o = 1'b1;
            err1_o    = pend_q.oob;
            rdata1_o  = (pend_q.we || pend_q.oob) ? 32'h0 : mem_rdata_i;
         end else begin
            rvalid0_o = 1'b1;
            err0_o    = pend_q.oob;
            rdata0_o  = pend_q.oob ? 32'h0 : mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter (round-robin and fixed instances)
module tb_imem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic        rst_n, req0, req1, we1, lock1;
   logic [31:0] addr0, addr1, wdata1;
   logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] ram [0:1023];

   logic        f_rst_n, f_req0, f_req1, f_we1, f_lock1;
   logic [31:0] f_addr0, f_addr1, f_wdata1;
   logic        f_gnt0, f_rvalid0, f_err0, f_gnt1, f_rvalid1, f_err1;
   logic [31:0] f_rdata0, f_rdata1;
   logic        f_mem_req, f_mem_we;
   logic [29:0] f_mem_addr;
   logic [31:0] f_mem_wdata, f_mem_rdata;
   logic [31:0] f_ram [0:1023];

   imem_arbiter #(.MEM_SIZE_BYTES(4096), .ARB_MODE(0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0), .rvalid0_o(rvalid0),
      .rdata0_o(rdata0), .err0_o(err0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .lock1_i(lock1),
      .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1), .err1_o(err1),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   imem_arbiter #(.MEM_SIZE_BYTES(4096), .ARB_MODE(1)) dut_fx (
      .clk_i(clk), .rst_ni(f_rst_n),
      .req0_i(f_req0), .addr0_i(f_addr0), .gnt0_o(f_gnt0), .rvalid0_o(f_rvalid0),
      .rdata0_o(f_rdata0), .err0_o(f_err0),
      .req1_i(f_req1), .we1_i(f_we1), .addr1_i(f_addr1), .wdata1_i(f_wdata1), .lock1_i(f_lock1),
      .gnt1_o(f_gnt1), .rvalid1_o(f_rvalid1), .rdata1_o(f_rdata1), .err1_o(f_err1),
      .mem_req_o(f_mem_req), .mem_we_o(f_mem_we), .mem_addr_o(f_mem_addr),
      .mem_wdata_o(f_mem_wdata), .mem_rdata_i(f_mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_req) begin
         mem_rdata <= ram[mem_addr[9:0]];
         if (mem_we) ram[mem_addr[9:0]] = mem_wdata;
      end
      if (f_mem_req) begin
         f_mem_rdata <= f_ram[f_mem_addr[9:0]];
         if (f_mem_we) f_ram[f_mem_addr[9:0]] = f_mem_wdata;
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i]   = exp_word(i);
         f_ram[i] = exp_word(i);
      end
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0;
      addr0 = 32'h10; addr1 = 32'h40; wdata1 = 32'h0;
      f_rst_n = 1'b0; f_req0 = 1'b1; f_req1 = 1'b1; f_we1 = 1'b0; f_lock1 = 1'b0;
      f_addr0 = 32'h8; f_addr1 = 32'h40; f_wdata1 = 32'h0;

      // reset held two cycles with both requests high
      tick();
      tick();
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_err0", err0, 0);
      chk("rst_err1", err1, 0);

      rst_n = 1'b1; req1 = 1'b0; addr0 = 32'h10;
      f_rst_n = 1'b1; f_req0 = 1'b0; f_req1 = 1'b0;
      #1;
      chk("first_gnt0", gnt0, 1);
      chk("first_gnt1", gnt1, 0);
      chk("first_mem_req", mem_req, 1);
      chk("first_mem_addr", 32'(mem_addr), 32'd4);
      tick();
      req0 = 1'b0;
      #1;
      chk("first_rvalid0", rvalid0, 1);
      chk("first_rdata0", rdata0, exp_word(4));
      chk("first_rvalid1", rvalid1, 0);
      chk("first_err0", err0, 0);

      // loader write
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hDEADBEEF;
      #1;
      chk("wr_gnt1", gnt1, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", 32'(mem_addr), 32'd8);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      req1 = 1'b0; we1 = 1'b0;
      #1;
      chk("wr_rvalid1", rvalid1, 1);
      chk("wr_rdata1", rdata1, 0);
      chk("wr_rvalid0", rvalid0, 0);

      // round-robin contention, pointer favours port 0 after the loader grant
      req0 = 1'b1; addr0 = 32'h0; req1 = 1'b1; addr1 = 32'h40;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         #1;
         chk($sformatf("rr_gnt0_%0d", k), gnt0, (k % 2 == 0));
         chk($sformatf("rr_gnt1_%0d", k), gnt1, (k % 2 == 1));
         chk($sformatf("rr_addr_%0d", k), 32'(mem_addr), (k % 2 == 0) ? 32'd0 : 32'd16);
         if (k > 0) begin
            chk($sformatf("rr_rvalid0_%0d", k), rvalid0, (k % 2 == 1));
            chk($sformatf("rr_rvalid1_%0d", k), rvalid1, (k % 2 == 0));
            if (k % 2 == 1) chk($sformatf("rr_rdata0_%0d", k), rdata0, exp_word(0));
            else            chk($sformatf("rr_rdata1_%0d", k), rdata1, exp_word(16));
         end
      end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("rr_last_rvalid1", rvalid1, 1);
      chk("rr_last_rdata1", rdata1, exp_word(16));

      // loader out-of-range write, top bit set
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8000_0000; wdata1 = 32'h1234_5678;
      #1;
      chk("ldoob_gnt1", gnt1, 1);
      chk("ldoob_mem_req", mem_req, 0);
      chk("ldoob_mem_we", mem_we, 0);
      tick();
      req1 = 1'b0; we1 = 1'b0;
      #1;
      chk("ldoob_rvalid1", rvalid1, 1);
      chk("ldoob_err1", err1, 1);
      chk("ldoob_rdata1", rdata1, 0);

      // fetch sees the loader's write
      req0 = 1'b1; addr0 = 32'h20;
      #1;
      chk("rb_gnt0", gnt0, 1);
      tick();
      req0 = 1'b0;
      #1;
      chk("rb_rvalid0", rvalid0, 1);
      chk("rb_rdata0", rdata0, 32'hDEADBEEF);

      // range boundary, back to back
      req0 = 1'b1; addr0 = 32'h1000;
      #1;
      chk("oob_gnt0", gnt0, 1);
      chk("oob_mem_req", mem_req, 0);
      tick();
      addr0 = 32'hFFC;
      #1;
      chk("oob_rvalid0", rvalid0, 1);
      chk("oob_err0", err0, 1);
      chk("oob_rdata0", rdata0, 0);
      chk("edge_gnt0", gnt0, 1);
      chk("edge_mem_req", mem_req, 1);
      chk("edge_mem_addr", 32'(mem_addr), 32'h3FF);
      tick();
      req0 = 1'b0;
      #1;
      chk("edge_rvalid0", rvalid0, 1);
      chk("edge_err0", err0, 0);
      chk("edge_rdata0", rdata0, exp_word(1023));

      // loader lock while fetch keeps requesting
      req0 = 1'b1; addr0 = 32'h0; req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 32'h44;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) tick();
         #1;
         chk($sformatf("lock_gnt0_%0d", j), gnt0, 0);
         chk($sformatf("lock_gnt1_%0d", j), gnt1, 1);
         if (j > 0) chk($sformatf("lock_rdata1_%0d", j), rdata1, exp_word(17));
      end
      tick();
      lock1 = 1'b0;
      #1;
      chk("unlock_gnt0", gnt0, 1);
      chk("unlock_gnt1", gnt1, 0);
      chk("unlock_rvalid1", rvalid1, 1);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("unlock_rvalid0", rvalid0, 1);
      chk("unlock_rdata0", rdata0, exp_word(0));

      // fixed priority instance
      f_req0 = 1'b1; f_addr0 = 32'h8; f_req1 = 1'b1; f_addr1 = 32'h40;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) tick();
         #1;
         chk($sformatf("fx_gnt0_%0d", j), f_gnt0, 1);
         chk($sformatf("fx_gnt1_%0d", j), f_gnt1, 0);
         if (j > 0) begin
            chk($sformatf("fx_rvalid0_%0d", j), f_rvalid0, 1);
            chk($sformatf("fx_rdata0_%0d", j), f_rdata0, exp_word(2));
         end
      end
      tick();
      f_rst_n = 1'b0;
      #1;
      chk("fx_rst_rvalid0", f_rvalid0, 0);
      chk("fx_rst_gnt0", f_gnt0, 0);
      tick();
      f_rst_n = 1'b1; f_req0 = 1'b0; f_req1 = 1'b0;
      #1;
      chk("fx_post_rvalid0", f_rvalid0, 0);
      chk("fx_post_rvalid1", f_rvalid1, 0);
      tick();
      chk("fx_post2_rvalid0", f_rvalid0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
